// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per clock.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               load,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] product,
  output logic               last_iter
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper;
  logic [CW-1:0]      cnt;
  logic               run;

  // Low half of acc holds the remaining multiplier bits; the sum enters the top.
  // product is the next accumulator value, complete on the last iteration.
  assign addend    = acc[0] ? mcand : '0;
  assign upper     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign product   = {upper, acc[WIDTH-1:1]};
  assign last_iter = run && (cnt == CW'(WIDTH-1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (load) begin
      acc   <= {{WIDTH{1'b0}}, B};
      mcand <= A;
      cnt   <= '0;
      run   <= 1'b1;
    end else if (run) begin
      acc <= product;
      cnt <= cnt + CW'(1);
      if (last_iter) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle FWD/ADD/AND/OR, iterative MUL and shifts,
// START/BUSY/DONE handshake and registered flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             NEGATIVE,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic             DONE
);

  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   sh_val, sh_nxt;
  logic [SHW-1:0]     sh_cnt;
  logic               sh_out;
  logic [SHW-1:0]     amt;
  logic               accept, is_shift, mul_last;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   s_res;
  logic               s_c, s_v;

  assign accept   = START && (state == IDLE);
  assign amt      = DATA2[SHW-1:0];
  assign is_shift = SELECT[2] && (SELECT != OP_MUL);
  assign add_full = {1'b0, DATA1} + {1'b0, DATA2};

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .load      (accept && (SELECT == OP_MUL)),
    .A         (DATA1),
    .B         (DATA2),
    .product   (product),
    .last_iter (mul_last)
  );

  // Results of ops that finish at the accepting edge (incl. zero-amount shifts).
  always_comb begin
    s_res = DATA1;
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (SELECT)
      OP_FWD: s_res = DATA2;
      OP_ADD: begin
        s_res = add_full[WIDTH-1:0];
        s_c   = add_full[WIDTH];
        s_v   = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) &&
                (add_full[WIDTH-1] != DATA1[WIDTH-1]);
      end
      OP_AND: s_res = DATA1 & DATA2;
      OP_OR:  s_res = DATA1 | DATA2;
      default: s_res = DATA1;
    endcase
  end

  always_comb begin
    sh_nxt = {sh_val[WIDTH-2:0], 1'b0};
    sh_out = sh_val[WIDTH-1];
    case (op_q)
      OP_SRL: begin sh_nxt = {1'b0, sh_val[WIDTH-1:1]};         sh_out = sh_val[0]; end
      OP_SRA: begin sh_nxt = {sh_val[WIDTH-1], sh_val[WIDTH-1:1]}; sh_out = sh_val[0]; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (START) begin
        if (SELECT == OP_MUL)           state_nxt = MUL;
        else if (is_shift && amt != '0) state_nxt = SHIFT;
      end
      MUL:     if (mul_last)             state_nxt = IDLE;
      SHIFT:   if (sh_cnt == SHW'(1))    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      RESULT   <= '0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
      DONE     <= 1'b0;
      op_q     <= OP_FWD;
      sh_val   <= '0;
      sh_cnt   <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          op_q <= SELECT;
          if (is_shift && amt != '0) begin
            sh_val <= DATA1;
            sh_cnt <= amt;
          end else if (SELECT != OP_MUL) begin
            RESULT   <= s_res;
            CARRY    <= s_c;
            OVERFLOW <= s_v;
            DONE     <= 1'b1;
          end
        end
        MUL: if (mul_last) begin
          RESULT   <= product[WIDTH-1:0];
          CARRY    <= 1'b0;
          OVERFLOW <= |product[2*WIDTH-1:WIDTH];
          DONE     <= 1'b1;
        end
        SHIFT: begin
          sh_val <= sh_nxt;
          sh_cnt <= sh_cnt - SHW'(1);
          if (sh_cnt == SHW'(1)) begin
            RESULT   <= sh_nxt;
            CARRY    <= sh_out;
            OVERFLOW <= 1'b0;
            DONE     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY     = (state != IDLE);
  assign ZERO     = (RESULT == '0);
  assign NEGATIVE = RESULT[WIDTH-1];

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): vector table through a scoreboard,
// plus hand sequences for ignored START and reset during a multiply.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       CLK = 1'b0, RESETN = 1'b1, START = 1'b0;
  logic [2:0] SELECT = 3'b000;
  logic [7:0] DATA1 = 8'h00, DATA2 = 8'h00;
  logic [7:0] RESULT;
  logic       ZERO, NEGATIVE, CARRY, OVERFLOW, BUSY, DONE;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .ZERO(ZERO),
    .NEGATIVE(NEGATIVE), .CARRY(CARRY), .OVERFLOW(OVERFLOW),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, res;
    logic       c, v, busy;
    int         dn;      // edge index after the accepting edge at which DONE rises
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       c, v;
    int         dn;
  } exp_t;

  localparam int NV = 15;
  vec_t tv[NV];
  exp_t sb[$];
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where DONE was seen.
  task automatic run_op(input vec_t t, input int idx);
    exp_t e;
    int   k;
    bit   seen;
    SELECT = t.op; DATA1 = t.a; DATA2 = t.b; START = 1'b1;
    sb.push_back('{res: t.res, c: t.c, v: t.v, dn: t.dn});
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0; DATA1 = ~t.a; DATA2 = t.b ^ 8'h5A; SELECT = ~t.op;
    chk($sformatf("v%0d busy", idx), BUSY, t.busy);
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      if (DONE) seen = 1;
      else begin
        @(posedge CLK); k++; @(negedge CLK);
      end
    end
    e = sb.pop_front();
    if (!seen) chk($sformatf("v%0d timeout", idx), 0, 1);
    else begin
      chk($sformatf("v%0d result", idx), RESULT, e.res);
      chk($sformatf("v%0d zero", idx), ZERO, e.res == 8'h00);
      chk($sformatf("v%0d negative", idx), NEGATIVE, e.res[7]);
      chk($sformatf("v%0d carry", idx), CARRY, e.c);
      chk($sformatf("v%0d overflow", idx), OVERFLOW, e.v);
      chk($sformatf("v%0d done_edge", idx), k, e.dn);
    end
  endtask

  initial begin
    int dcnt, dk;
    //            op      a      b      res    c  v  busy dn
    tv[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0};
    tv[1]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 0, 0, 0};
    tv[2]  = '{OP_MUL, 8'h0D, 8'h0B, 8'h8F, 0, 0, 1, 8};
    tv[3]  = '{OP_MUL, 8'h20, 8'h10, 8'h00, 0, 1, 1, 8};
    tv[4]  = '{OP_SRA, 8'h94, 8'h03, 8'hF2, 1, 0, 1, 3};
    tv[5]  = '{OP_SLL, 8'h81, 8'h00, 8'h81, 0, 0, 0, 0};
    tv[6]  = '{OP_FWD, 8'h12, 8'hA5, 8'hA5, 0, 0, 0, 0};
    tv[7]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0};
    tv[8]  = '{OP_OR,  8'hF0, 8'h3C, 8'hFC, 0, 0, 0, 0};
    tv[9]  = '{OP_SLL, 8'h81, 8'h01, 8'h02, 1, 0, 1, 1};
    tv[10] = '{OP_SRL, 8'h81, 8'h07, 8'h01, 0, 0, 1, 7};
    tv[11] = '{OP_SLL, 8'hF1, 8'h04, 8'h10, 1, 0, 1, 4};
    tv[12] = '{OP_SRA, 8'h7F, 8'h07, 8'h00, 1, 0, 1, 7};
    tv[13] = '{OP_SRL, 8'h80, 8'hFA, 8'h20, 0, 0, 1, 2};
    tv[14] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 0, 1, 1, 8};

    #2 RESETN = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset result", RESULT, 8'h00);
    chk("reset zero", ZERO, 1);
    chk("reset flags", {NEGATIVE, CARRY, OVERFLOW}, 3'b000);
    chk("reset busy_done", {BUSY, DONE}, 2'b00);
    RESETN = 1'b1;
    @(negedge CLK);
    chk("no done after reset", DONE, 0);

    // Back-to-back: each op starts in the cycle its predecessor's DONE is high.
    for (int i = 0; i < NV; i++) run_op(tv[i], i);
    @(negedge CLK);
    chk("single done pulse", DONE, 0);
    chk("idle after table", BUSY, 0);

    // START while busy must be ignored; MUL completes with captured operands.
    SELECT = OP_MUL; DATA1 = 8'h0D; DATA2 = 8'h0B; START = 1'b1;
    @(posedge CLK);
    dcnt = 0; dk = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      START = (k == 1);
      if (k == 1) begin SELECT = OP_ADD; DATA1 = 8'h01; DATA2 = 8'h01; end
      if (DONE) begin dcnt++; dk = k - 1; end
      if (k - 1 == 8) chk("ignored start result", RESULT, 8'h8F);
      @(posedge CLK);
    end
    chk("ignored start done count", dcnt, 1);
    chk("ignored start done edge", dk, 8);

    // Reset during a MUL aborts it without a DONE.
    @(negedge CLK);
    SELECT = OP_MUL; DATA1 = 8'h05; DATA2 = 8'h07; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(posedge CLK);
    @(posedge CLK);
    #2 RESETN = 1'b0;
    #1;
    chk("midreset busy", BUSY, 0);
    chk("midreset done", DONE, 0);
    chk("midreset result", RESULT, 8'h00);
    chk("midreset zero", ZERO, 1);
    @(negedge CLK);
    RESETN = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(negedge CLK);
      if (DONE) dcnt++;
    end
    chk("midreset no done", dcnt, 0);
    chk("midreset idle", BUSY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the datapath's 8-bit combinational ALU. Keeps the FORWARD, ADD, AND and OR opcodes. Adds an iterative unsigned multiply and three iterative shifts, a registered START/BUSY/DONE handshake, and a full flag set. Sits in the execute stage; the CPU control unit stalls the PC while BUSY=1. Operand muxing and two's-complement negation for SUB stay outside the block, as today.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, at least 4.
SHW, $clog2(WIDTH), shift-amount field width; derived, not overridden.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RESETN  input  1  asynchronous, active-low reset.
START  input  1  request; sampled at a rising edge only while BUSY=0.
SELECT  input  3  opcode: 000 FWD, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRL, 111 SRA.
DATA1  input  WIDTH  operand A; the shift source.
DATA2  input  WIDTH  operand B; the shift amount is DATA2[SHW-1:0].
RESULT  output  WIDTH  registered result; holds until the next completion.
ZERO  output  1  RESULT == 0 (branch condition).
NEGATIVE  output  1  RESULT[WIDTH-1].
CARRY  output  1  registered carry flag.
OVERFLOW  output  1  registered overflow flag.
BUSY  output  1  multi-cycle operation in progress.
DONE  output  1  one-cycle pulse: RESULT/flags updated at this edge.

Behaviour:
- Reset (RESETN=0, asynchronous):
  - RESULT=0, ZERO=1, NEGATIVE=0, CARRY=0, OVERFLOW=0, BUSY=0, DONE=0, FSM=IDLE.
  - Reset mid-operation aborts the operation, discards partial state and produces no DONE.
- FSM states: IDLE, MUL, SHIFT.
  - Only IDLE accepts START.
  - START while BUSY=1 is ignored. Operands and SELECT are not re-sampled.
- Operand capture: at the accepting edge E0, SELECT, DATA1 and DATA2 are latched. Input changes after E0 have no effect.
- Single-cycle ops (FWD, ADD, AND, OR, and any shift with amount 0):
  - RESULT and flags are written at E0, with DONE=1 for the following cycle.
  - BUSY stays 0. Latency 1.
  - FWD returns DATA2. A shift with amount 0 returns DATA1 with CARRY=0.
- MUL (unsigned shift-add, one partial product per cycle):
  - FSM moves IDLE->MUL at E0, and BUSY=1 after E0.
  - Iterations run at E1..E_WIDTH. At E_WIDTH: RESULT = product[WIDTH-1:0], BUSY=0, DONE=1, FSM->IDLE.
  - Latency WIDTH cycles.
  - Needs a 2*WIDTH-bit accumulator.
- Shifts (amount n, 1 <= n <= WIDTH-1):
  - FSM moves IDLE->SHIFT at E0. One bit per edge; completes at E_n with BUSY=0 and DONE=1.
  - Upper bits of DATA2 above SHW are ignored.
  - SLL and SRL zero-fill. SRA replicates the sign bit.
- Flags are registered with RESULT at completion and hold otherwise:
  - ADD: CARRY = carry-out of bit WIDTH-1. OVERFLOW = signed overflow (operands same sign, result differs).
  - MUL: CARRY=0. OVERFLOW = (product[2*WIDTH-1:WIDTH] != 0).
  - Shifts: CARRY = last bit shifted out. OVERFLOW=0.
  - FWD, AND, OR: CARRY=0, OVERFLOW=0.
  - ZERO and NEGATIVE are derived from the registered RESULT.
- DONE is high for exactly one cycle per accepted START. A new START may be accepted in the same cycle DONE is high, since BUSY=0.

Decomposition:
- Package alu_seq_pkg: the 3-bit opcode localparams (OP_FWD..OP_SRA) and the FSM state encoding (IDLE=2'd0, MUL=2'd1, SHIFT=2'd2).
- One sub-module, alu_seq_mul: the iterative multiplier datapath.
  - Inputs: CLK, RESETN, load, A, B.
  - Outputs: product, last_iter.
  - Owns the 2*WIDTH-bit accumulator and its iteration counter.
- The shifter, the single-cycle ops and the flag logic stay in alu_seq.

Test Plan (WIDTH=8):
1. Assert RESETN=0 mid-run -> RESULT=8'h00, ZERO=1, BUSY=0, DONE=0 immediately; release, with no spurious DONE.
2. ADD 8'h7F+8'h01 -> one cycle after the START edge: RESULT=8'h80, NEGATIVE=1, OVERFLOW=1, CARRY=0, single DONE pulse, BUSY never 1.
3. ADD 8'hFF+8'h01 -> RESULT=8'h00, ZERO=1, CARRY=1, OVERFLOW=0.
4. MUL 8'h0D*8'h0B -> BUSY for 8 cycles, DONE at E8, RESULT=8'h8F, OVERFLOW=0; then MUL 8'h20*8'h10 -> RESULT=8'h00, ZERO=1, OVERFLOW=1.
5. SRA 8'h94 by 3 -> DONE at E3, RESULT=8'hF2, CARRY=1, NEGATIVE=1; SLL 8'h81 by 0 -> latency 1, RESULT=8'h81, CARRY=0.
6. Start MUL, pulse START with SELECT=ADD at E2 -> ignored; MUL completes unchanged at E8. Then assert RESETN=0 at E4 of a new MUL -> BUSY=0, no DONE, RESULT=8'h00.
